brentkung_sub_pipe: RTL and testbench
=====================================

Name: brentkung_sub_pipe

Overview:
- Inverse of the team's combinational 12-bit Brent-Kung adder. Given a 13-bit sum and one 12-bit addend, it recovers the other addend: B = SUM - A.
- Used on the checker/readback side to reconstruct operands from adder results.
- Two-stage pipelined Brent-Kung subtractor with valid/ready handshake on both sides.
- Split point: stage 1 resolves the low half, stage 2 the high half.

Parameters:
- WIDTH, default 12: addend width. Sum width is WIDTH+1. Must be even and >= 4.
- HALF, default WIDTH/2: split point between stage 1 and stage 2. Derived; not to be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- in_sum  in  WIDTH+1  sum operand.
- in_a  in  WIDTH  known addend.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_b  out  WIDTH  recovered addend, (in_sum - in_a) mod 2^WIDTH.
- out_err  out  1  true difference lies outside [0, 2^WIDTH-1].

Behaviour:
- Reset and clocking:
  - Only one clock domain.
  - rst_n low asynchronously clears s1_valid, s2_valid, out_b and out_err to 0.
  - All other registers also reset to 0.
- Accept rule: a transfer occurs when in_valid && in_ready at a rising edge.
- Stage 1:
  - Computes low[HALF-1:0] = in_sum[HALF-1:0] - in_a[HALF-1:0] as in_sum + ~in_a + 1, using a Brent-Kung prefix network of generate/propagate terms.
  - Registers the low result, the carry out of bit HALF-1, and in_sum[WIDTH:HALF] and in_a[WIDTH-1:HALF].
- Stage 2:
  - Completes the upper bits with a second Brent-Kung prefix network, using the registered carry as carry-in.
  - Zero-extends A to WIDTH+1 bits.
- Result:
  - Full difference d is WIDTH+2 bits signed.
  - out_b = d[WIDTH-1:0].
  - out_err = 1 when d < 0 (final carry out = 0) or when d[WIDTH] = 1.
- Latency: exactly 2 cycles from accept to out_valid when there is no stall. Throughput is 1 result per cycle.
- Pipeline control:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = !s1_valid || s2 advances (combinational from out_ready; this path is permitted).
- Stall: while out_valid && !out_ready, out_b and out_err hold stable and out_valid stays high. No data is dropped or duplicated; results leave in order.
- Bubbles: in_valid low produces bubbles. out_valid drops when the pipe drains.
- Simultaneous accept and emit in the same cycle is legal, and the pipe stays full.
- Reset mid-operation: in-flight transactions are discarded. out_valid is 0 the same instant rst_n falls. in_ready is 1 in the first cycle after rst_n rises.
- Pipeline registers without valid do not need to hold meaningful data, but outputs must be 0 after reset.

Test Plan:
- Basic: SUM=13'h1FFE, A=12'hFFF accepted at cycle 0 -> cycle 2: out_valid=1, out_b=12'hFFF, out_err=0.
- Underflow: SUM=13'h0000, A=12'h001 -> out_b=12'hFFF, out_err=1. Second case SUM=13'h0040, A=12'h041, which borrows across the half boundary -> out_b=12'hFFF, out_err=1.
- Overflow: SUM=13'h1000, A=12'h000 -> out_b=12'h000, out_err=1. SUM=13'h1000, A=12'h001 -> out_b=12'hFFF, out_err=0.
- Backpressure: send 4 back-to-back inputs (B=1,2,3,4) with out_ready=0 for cycles 1-5.
  - in_ready must be 0 once 2 entries are held.
  - out_b=1 must stay stable while stalled.
  - After release the bench must see 1, 2, 3, 4 in consecutive cycles with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with both stages valid -> out_valid=0, out_b=0 immediately. After release, no stale result appears and the first new input emerges 2 cycles after accept.
- Random: 10k pairs with A, B uniform 12-bit, SUM=A+B, random in_valid/out_ready -> out_b==B, out_err=0 for every result, in order.

Source files
------------

// File: rtl/brentkung_sub_pipe.sv
// Two-stage pipelined Brent-Kung subtractor: recovers B = SUM - A from an adder result.
// Stage 1 resolves the low half of the difference and stage 2 resolves the high half.

module brentkung_sub_pipe_bk #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  localparam int unsigned LG = $clog2(N);

  logic [N-1:0] p;
  logic [N-1:0] gg;
  logic [N-1:0] pp;
  int unsigned  dd;

  always_comb begin
    p     = x ^ y;
    gg    = x & y;
    pp    = p;
    dd    = 0;
    // cin is folded into the bit-0 generate, so every group generate is a true carry
    gg[0] = gg[0] | (p[0] & cin);
    for (int unsigned d = 1; d < N; d = d << 1) begin
      for (int unsigned i = 2 * d - 1; i < N; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int unsigned k = 0; k < LG; k++) begin
      dd = 1 << (LG - 1 - k);
      for (int unsigned i = 3 * dd - 1; i < N; i = i + 2 * dd) begin
        gg[i] = gg[i] | (pp[i] & gg[i-dd]);
        pp[i] = pp[i] & pp[i-dd];
      end
    end
  end

  assign s    = p ^ {gg[N-2:0], cin};
  assign cout = gg[N-1];
endmodule

module brentkung_sub_pipe #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err
);
  localparam int HALF = WIDTH / 2;
  localparam int HW   = WIDTH - HALF + 1;

  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] s1_low_q, s1_low_d;
  logic            s1_cy_q, s1_cy_d;
  logic [HW-1:0]   s1_sum_hi_q, s1_sum_hi_d;
  logic [HW-2:0]   s1_a_hi_q, s1_a_hi_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_b_q, s2_b_d;
  logic             s2_err_q, s2_err_d;

  logic            s1_adv, s2_adv;
  logic [HALF-1:0] low;
  logic            low_cy;
  logic [HW-1:0]   hi;
  logic            hi_cy;
  logic [HALF-1:0] a_lo_n;
  logic [HW-1:0]   a_hi_n;

  assign a_lo_n = ~in_a[HALF-1:0];
  assign a_hi_n = ~{1'b0, s1_a_hi_q};

  brentkung_sub_pipe_bk #(.N(HALF)) u_lo (
    .x    (in_sum[HALF-1:0]),
    .y    (a_lo_n),
    .cin  (1'b1),
    .s    (low),
    .cout (low_cy)
  );

  brentkung_sub_pipe_bk #(.N(HW)) u_hi (
    .x    (s1_sum_hi_q),
    .y    (a_hi_n),
    .cin  (s1_cy_q),
    .s    (hi),
    .cout (hi_cy)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_low_d    = s1_low_q;
    s1_cy_d     = s1_cy_q;
    s1_sum_hi_d = s1_sum_hi_q;
    s1_a_hi_d   = s1_a_hi_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_low_d    = low;
        s1_cy_d     = low_cy;
        s1_sum_hi_d = in_sum[WIDTH:HALF];
        s1_a_hi_d   = in_a[WIDTH-1:HALF];
      end
    end
  end

  // Final carry clear means a negative difference; hi[HW-1] set means it exceeds WIDTH bits
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_b_d     = s2_b_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_b_d   = {hi[HW-2:0], s1_low_q};
        s2_err_d = !hi_cy || hi[HW-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_low_q    <= '0;
      s1_cy_q     <= 1'b0;
      s1_sum_hi_q <= '0;
      s1_a_hi_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_b_q      <= '0;
      s2_err_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_low_q    <= s1_low_d;
      s1_cy_q     <= s1_cy_d;
      s1_sum_hi_q <= s1_sum_hi_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s2_valid_q  <= s2_valid_d;
      s2_b_q      <= s2_b_d;
      s2_err_q    <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_b     = s2_b_q;
  assign out_err   = s2_err_q;
endmodule

// File: tb/tb_brentkung_sub_pipe.sv
// Directed and randomized checks for brentkung_sub_pipe: values, latency, stall, reset, ordering.

module tb_brentkung_sub_pipe;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   in_sum = '0;
  logic [W-1:0] in_a = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_b;
  logic         out_err;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  logic [W:0] exp_q[$];

  brentkung_sub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: reference difference from plain integer arithmetic, results checked in order
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        int d;
        logic [W:0] e;
        d = int'(in_sum) - int'(in_a);
        e = {(d < 0) || (d > 4095), d[W-1:0]};
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("sb_b", 32'(out_b), 32'(e[W-1:0]));
          check("sb_err", 32'(out_err), 32'(e[W]));
          rx_cnt++;
        end
      end
    end
  end

  task automatic run_vec(input string tag, input logic [W:0] sum, input logic [W-1:0] a,
                         input logic [W-1:0] eb, input logic ee);
    int n;
    in_sum    = sum;
    in_a      = a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 2);
    check({tag, "_b"}, 32'(out_b), 32'(eb));
    check({tag, "_err"}, 32'(out_err), 32'(ee));
    tick();
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [W:0]   sum;
    logic         acc;
    int           guard;
    int           rx0;

    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_b", 32'(out_b), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("rst_rdy", 32'(in_ready), 32'd1);

    run_vec("basic",  13'h1FFE, 12'hFFF, 12'hFFF, 1'b0);
    run_vec("under0", 13'h0000, 12'h001, 12'hFFF, 1'b1);
    run_vec("under1", 13'h0040, 12'h041, 12'hFFF, 1'b1);
    run_vec("over0",  13'h1000, 12'h000, 12'h000, 1'b1);
    run_vec("over1",  13'h1000, 12'h001, 12'hFFF, 1'b0);
    run_vec("over2",  13'h1FFF, 12'hFFF, 12'h000, 1'b1);
    run_vec("mid",    13'h0123, 12'h023, 12'h100, 1'b0);
    run_vec("max",    13'h0FFF, 12'h000, 12'hFFF, 1'b0);

    // Backpressure: out_ready held low while four items with B=1..4 are offered
    out_ready = 1'b0;
    in_a      = 12'h0F0;
    in_sum    = 13'h0F1;
    in_valid  = 1'b1;
    #1 check("bp_rdy0", 32'(in_ready), 32'd1);
    tick();
    in_sum = 13'h0F2;
    tick();
    in_sum = 13'h0F3;
    check("bp_full", 32'(in_ready), 32'd0);
    check("bp_v", 32'(out_valid), 32'd1);
    check("bp_b", 32'(out_b), 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
      check("bp_hold_v", 32'(out_valid), 32'd1);
      check("bp_hold_b", 32'(out_b), 32'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_rel_rdy", 32'(in_ready), 32'd1);
    tick();
    check("bp_out2", 32'(out_b), 32'd2);
    check("bp_out2_v", 32'(out_valid), 32'd1);
    in_sum = 13'h0F4;
    tick();
    in_valid = 1'b0;
    check("bp_out3", 32'(out_b), 32'd3);
    check("bp_out3_v", 32'(out_valid), 32'd1);
    tick();
    check("bp_out4", 32'(out_b), 32'd4);
    check("bp_out4_v", 32'(out_valid), 32'd1);
    tick();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Reset with both stages holding data
    out_ready = 1'b0;
    in_a      = 12'h222;
    in_sum    = 13'h0333;
    in_valid  = 1'b1;
    tick();
    in_sum = 13'h0444;
    tick();
    in_valid = 1'b0;
    check("mr_full", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_b", 32'(out_b), 32'd0);
    check("mr_err", 32'(out_err), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("mr_rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      check("mr_stale", 32'(out_valid), 32'd0);
      tick();
    end
    run_vec("mr_new", 13'h0800, 12'h123, 12'h6DD, 1'b0);

    // Random traffic: SUM = A + B with random valid/ready
    rx0 = rx_cnt;
    for (int unsigned n = 0; n < 10000; n++) begin
      a   = 12'($urandom);
      b   = 12'($urandom);
      sum = {1'b0, a} + {1'b0, b};
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 64) begin
        tick();
        in_sum    = sum;
        in_a      = a;
        in_valid  = ($urandom_range(3, 0) != 0);
        out_ready = ($urandom_range(3, 0) != 0);
        #1 acc = in_valid && in_ready;
        guard++;
      end
      if (!acc) check("rnd_accept", 32'd0, 32'd1);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("rnd_drain", exp_q.size(), 0);
    check("rnd_count", rx_cnt - rx0, 10000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
